led_fade_ctrl: RTL and testbench
================================

# led_fade_ctrl

Duty-cycle sequencer for the LED PWM datapath. It accepts commands over a valid/ready handshake: set a duty immediately, ramp to a target, or breathe continuously. It drives a 7-bit duty value (0–100) into a PWM instance. It keeps a frame counter in lockstep with the PWM period, so duty changes happen only at period boundaries and the LED never sees a truncated or glitched pulse.

## Interface
- PERIOD, 101: PWM frame length in clocks; must equal the PWM counter's 0..100 cycle.
- MAX_DC, 100: maximum legal duty; larger targets are clamped.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_mode  in  2  00 SET, 01 RAMP, 10 BREATHE, 11 reserved (treated as SET).
- cmd_target  in  7  target duty (0..127; clamped to MAX_DC).
- cmd_rate  in  8  frames per 1-unit duty step; 0 treated as 1.
- stop  in  1  abort the current sequence and hold the present duty.
- dc  out  7  duty to the PWM.
- frame_start  out  1  one-cycle pulse on the first clock of each PWM frame.
- busy  out  1  a sequence is active.
- done  out  1  one-cycle pulse when SET or RAMP completes.

## Operation
- Frame counter fcnt counts 0..PERIOD-1 and wraps. Define frame_tick = (fcnt == PERIOD-1).
- frame_start is registered and high on the cycle where fcnt == 0.
- A command is accepted when cmd_valid && cmd_ready. On acceptance the block latches mode, target (min(cmd_target, MAX_DC)) and rate (max(cmd_rate, 1)). It also clears the step counter scnt.
- cmd_ready = (state == IDLE || state == BREATHE) && !stop. A new command pre-empts BREATHE.
- States:
  - IDLE: busy = 0.
  - SET_WAIT: on frame_tick, dc <= target, done pulse, go to IDLE.
  - RAMP: on frame_tick, scnt increments. When scnt reaches rate-1, scnt <= 0 and dc steps by 1 toward target. On the step where dc becomes target, done pulses and the state goes to IDLE.
  - A RAMP command with target == dc: done pulses at the next frame_tick and the state goes to IDLE; dc is unchanged.
  - BREATHE: uses the same step timing with a direction bit.
    - Going up: when dc reaches target, the direction flips.
    - Going down: when dc reaches 0, the direction flips.
    - Entry direction is up if dc < target, otherwise down.
    - target == 0 holds dc at 0.
    - done is never pulsed. The sequence runs until stop or a new command.
- stop is valid in any state. On the next clock: state <= IDLE, dc is held, no done pulse, scnt cleared.
- stop and cmd_valid in the same cycle: stop wins and the command is not accepted.
- dc changes only on the clock edge at which frame_tick is high, so the new value is visible from fcnt == 0 onward.
- dc is always within 0..MAX_DC; all arithmetic saturates, with no 7-bit wrap.

## Timing
- Reset (asynchronous assert; deassert on a clk edge):
  - fcnt = 0, scnt = 0, state = IDLE.
  - dc = 0, busy = 0, done = 0.
  - frame_start = 1 on the first cycle after release.
  - cmd_ready = 1 once rst_n is high.
- Reset mid-sequence immediately forces dc = 0 and abandons the sequence.
- Command accepted at edge k: state and busy update at k+1. dc is unchanged until the first frame_tick after k.
- SET latency: dc updates at the next frame boundary, 1..PERIOD clocks after acceptance.
- RAMP and BREATHE: one step every rate × PERIOD clocks. The first step lands at the rate-th frame_tick after acceptance.
- done: registered, high for exactly one cycle, coincident with the dc update. busy drops on the same cycle.
- fcnt free-runs and is unaffected by commands and stop.

## Test plan
- Reset, then hold rst_n high with no commands:
  - dc = 0, busy = 0, cmd_ready = 1.
  - frame_start pulses every 101 clocks.
- SET target 60 mid-frame:
  - dc goes 0→60 exactly at the next fcnt wrap.
  - done pulses once.
  - busy is high only between acceptance and done.
- RAMP from 0, target 10, rate 2:
  - dc increments every 202 clocks, reaching 10 after 20 frames.
  - done pulses on that cycle.
  - dc stays at 10 afterwards.
- RAMP target 120:
  - Clamped; dc saturates at 100 and never exceeds it.
- RAMP target 0 from dc 30:
  - dc descends to 0, then done.
- RAMP with target equal to the current dc:
  - done pulses at the next frame_tick; dc is unchanged.
- BREATHE target 4, rate 1:
  - dc sequence per frame is 0,1,2,3,4,3,2,1,0,1…
  - stop at dc = 3 holds 3, returns to IDLE, no done.
- stop asserted with cmd_valid in the same cycle:
  - Command not accepted.
- Assert rst_n low mid-RAMP at dc = 57:
  - dc = 0 asynchronously.
  - After release, the block is in IDLE and fcnt restarts at 0.

Source files
------------

// File: rtl/led_fade_ctrl_if.sv
// Command channel for led_fade_ctrl: valid/ready handshake carrying mode, target and rate.
interface led_fade_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [6:0] cmd_target;
  logic [7:0] cmd_rate;

  modport master (output cmd_valid, cmd_mode, cmd_target, cmd_rate, input cmd_ready);
  modport slave  (input cmd_valid, cmd_mode, cmd_target, cmd_rate, output cmd_ready);
endinterface

// File: rtl/led_fade_ctrl.sv
// Duty-cycle sequencer: SET / RAMP / BREATHE commands, duty changes only at PWM frame boundaries.
module led_fade_ctrl #(
  parameter int PERIOD = 101,
  parameter int MAX_DC = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_fade_ctrl_if.slave       cmd,
  input  logic                 stop,
  output logic [6:0]           dc,
  output logic                 frame_start,
  output logic                 busy,
  output logic                 done
);
  localparam int FW = $clog2(PERIOD);

  typedef enum logic [1:0] {IDLE, SET_WAIT, RAMP, BREATHE} state_e;

  state_e        r_state, w_state_nxt;
  logic [FW-1:0] r_fcnt;
  logic [6:0]    r_dc, w_dc_nxt, r_tgt, w_tgt_nxt;
  logic [7:0]    r_rate, w_rate_nxt, r_scnt, w_scnt_nxt;
  logic          r_up, w_up_nxt, r_done, w_done_nxt, r_fstart;
  logic          w_tick, w_step, w_accept;
  logic [6:0]    w_tgt_clamp, w_dc_inc, w_dc_dec, w_ramp_dc;

  assign w_tick      = (r_fcnt == FW'(PERIOD - 1));
  assign w_step      = (r_scnt == r_rate - 8'd1);
  assign cmd.cmd_ready = ((r_state == IDLE) || (r_state == BREATHE)) && !stop;
  assign w_accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign w_tgt_clamp = (cmd.cmd_target > 7'(MAX_DC)) ? 7'(MAX_DC) : cmd.cmd_target;
  // saturating neighbours of dc; keeps the register inside 0..MAX_DC
  assign w_dc_inc    = (r_dc >= 7'(MAX_DC)) ? r_dc : r_dc + 7'd1;
  assign w_dc_dec    = (r_dc == 7'd0) ? r_dc : r_dc - 7'd1;
  assign w_ramp_dc   = (r_dc < r_tgt) ? w_dc_inc : w_dc_dec;

  always_comb begin
    w_state_nxt = r_state;
    w_dc_nxt    = r_dc;
    w_tgt_nxt   = r_tgt;
    w_rate_nxt  = r_rate;
    w_scnt_nxt  = r_scnt;
    w_up_nxt    = r_up;
    w_done_nxt  = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
      w_scnt_nxt  = '0;
    end else if (w_accept) begin
      w_tgt_nxt  = w_tgt_clamp;
      w_rate_nxt = (cmd.cmd_rate == 8'd0) ? 8'd1 : cmd.cmd_rate;
      w_scnt_nxt = '0;
      case (cmd.cmd_mode)
        2'b01:   w_state_nxt = RAMP;
        2'b10: begin
          w_state_nxt = BREATHE;
          w_up_nxt    = (r_dc < w_tgt_clamp);
        end
        default: w_state_nxt = SET_WAIT;
      endcase
    end else if (w_tick) begin
      case (r_state)
        SET_WAIT: begin
          w_dc_nxt    = r_tgt;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
        RAMP: begin
          if (r_dc == r_tgt) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_step) begin
            w_scnt_nxt = '0;
            w_dc_nxt   = w_ramp_dc;
            if (w_ramp_dc == r_tgt) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end
          end else begin
            w_scnt_nxt = r_scnt + 8'd1;
          end
        end
        BREATHE: begin
          if (w_step) begin
            w_scnt_nxt = '0;
            if (r_up) begin
              if (r_dc < r_tgt) w_dc_nxt = w_dc_inc;
              if (w_dc_inc >= r_tgt) w_up_nxt = 1'b0;
            end else begin
              w_dc_nxt = w_dc_dec;
              // a zero target pins dc at 0 instead of bouncing
              if (w_dc_dec == 7'd0 && r_tgt != 7'd0) w_up_nxt = 1'b1;
            end
          end else begin
            w_scnt_nxt = r_scnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_fcnt   <= '0;
      r_dc     <= '0;
      r_tgt    <= '0;
      r_rate   <= 8'd1;
      r_scnt   <= '0;
      r_up     <= 1'b0;
      r_done   <= 1'b0;
      r_fstart <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_fcnt   <= w_tick ? '0 : r_fcnt + FW'(1);
      r_dc     <= w_dc_nxt;
      r_tgt    <= w_tgt_nxt;
      r_rate   <= w_rate_nxt;
      r_scnt   <= w_scnt_nxt;
      r_up     <= w_up_nxt;
      r_done   <= w_done_nxt;
      r_fstart <= w_tick;
    end
  end

  assign dc          = r_dc;
  assign frame_start = r_fstart;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl: directed scenarios plus randomized traffic against a frame-level model.
module tb_led_fade_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop;
  logic [6:0] dc;
  logic       frame_start, busy, done;

  led_fade_ctrl_if cmd();

  led_fade_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .stop(stop),
    .dc(dc), .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_done = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Frame-level model: counts frame ticks since acceptance; a step lands every rate-th tick.
  typedef enum {M_IDLE, M_SET, M_RAMP, M_BR} mst_e;
  mst_e m_st;
  int   m_fcnt, m_dc, m_tgt, m_rate, m_ticks;
  bit   m_up, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = M_IDLE; m_fcnt = 0; m_dc = 0; m_done = 0; m_ticks = 0;
    end else begin
      bit tick, rdy;
      tick   = (m_fcnt == 100);
      rdy    = (m_st == M_IDLE || m_st == M_BR) && !stop;
      m_done = 0;
      if (stop) begin
        m_st = M_IDLE;
      end else if (cmd.cmd_valid && rdy) begin
        m_tgt   = (cmd.cmd_target > 100) ? 100 : int'(cmd.cmd_target);
        m_rate  = (cmd.cmd_rate == 0) ? 1 : int'(cmd.cmd_rate);
        m_ticks = 0;
        case (cmd.cmd_mode)
          2'd1: m_st = M_RAMP;
          2'd2: begin m_st = M_BR; m_up = (m_dc < m_tgt); end
          default: m_st = M_SET;
        endcase
      end else if (tick && m_st != M_IDLE) begin
        m_ticks++;
        case (m_st)
          M_SET: begin m_dc = m_tgt; m_done = 1; m_st = M_IDLE; end
          M_RAMP: begin
            if (m_dc == m_tgt) begin
              m_done = 1; m_st = M_IDLE;
            end else if (m_ticks % m_rate == 0) begin
              m_dc += (m_dc < m_tgt) ? 1 : -1;
              if (m_dc == m_tgt) begin m_done = 1; m_st = M_IDLE; end
            end
          end
          M_BR: begin
            if (m_ticks % m_rate == 0) begin
              if (m_up) begin
                m_dc++;
                if (m_dc == m_tgt) m_up = 0;
              end else if (m_dc > 0) begin
                m_dc--;
                if (m_dc == 0 && m_tgt > 0) m_up = 1;
              end
            end
          end
          default: ;
        endcase
      end
      m_fcnt = tick ? 0 : m_fcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("dc", int'(dc), m_dc);
      chk("busy", int'(busy), int'(m_st != M_IDLE));
      chk("done", int'(done), int'(m_done));
      chk("frame_start", int'(frame_start), int'(m_fcnt == 0));
      chk("cmd_ready", int'(cmd.cmd_ready), int'((m_st == M_IDLE || m_st == M_BR) && !stop));
      chk("dc_range", int'(dc <= 7'd100), 1);
      if (done) n_done++;
    end
  end

  task automatic send(input int mode, input int tgt, input int rate);
    @(posedge clk); #2;
    cmd.cmd_valid = 1'b1; cmd.cmd_mode = 2'(mode);
    cmd.cmd_target = 7'(tgt); cmd.cmd_rate = 8'(rate);
    @(posedge clk); #2;
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < budget);
    if (!done) chk({nm, "_timeout"}, cyc, -1);
  endtask

  task automatic wait_dc(input string nm, input int val, input int budget);
    int c = 0;
    while (int'(dc) != val && c < budget) begin @(negedge clk); c++; end
    if (int'(dc) != val) chk({nm, "_timeout"}, int'(dc), val);
  endtask

  initial begin
    int n, fr, d0;
    int exp_br[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
    cmd.cmd_valid = 1'b0; cmd.cmd_mode = '0; cmd.cmd_target = '0; cmd.cmd_rate = '0;
    stop = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk); #2 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_dc", int'(dc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd.cmd_ready), 1);
    chk("rst_fstart", int'(frame_start), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 200);
    chk("fs_period", n, 101);

    repeat (40) @(negedge clk);
    send(0, 60, 0);
    wait_done("set60", 150, n);
    chk("set60_dc", int'(dc), 60);
    chk("set60_fstart", int'(frame_start), 1);
    @(negedge clk);
    chk("set60_done_once", int'(done), 0);
    chk("set60_busy", int'(busy), 0);

    send(0, 0, 0);
    wait_done("set0", 150, n);
    send(1, 10, 2);
    fr = 0; n = 0;
    do begin @(negedge clk); n++; if (frame_start) fr++; end while (!done && n < 3000);
    chk("ramp10_frames", fr, 20);
    chk("ramp10_dc", int'(dc), 10);

    send(1, 120, 1);
    wait_done("ramp120", 11000, n);
    chk("ramp120_dc", int'(dc), 100);

    send(0, 30, 0);
    wait_done("set30", 150, n);
    send(1, 0, 1);
    wait_done("ramp0", 3300, n);
    chk("ramp0_dc", int'(dc), 0);

    send(1, 0, 5);
    wait_done("ramp_eq", 110, n);
    chk("ramp_eq_lat", int'(n <= 101), 1);
    chk("ramp_eq_dc", int'(dc), 0);

    send(2, 4, 1);
    for (int i = 0; i < 9; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_start && n < 200);
      chk($sformatf("breathe_%0d", i), int'(dc), exp_br[i]);
    end
    wait_dc("breathe3", 3, 500);
    d0 = n_done;
    @(posedge clk); #2 stop = 1'b1;
    @(posedge clk); #2 stop = 1'b0;
    repeat (250) @(negedge clk);
    chk("stop_dc", int'(dc), 3);
    chk("stop_busy", int'(busy), 0);
    chk("stop_nodone", n_done, d0);

    @(posedge clk); #2;
    stop = 1'b1; cmd.cmd_valid = 1'b1; cmd.cmd_mode = 2'd0; cmd.cmd_target = 7'd77;
    @(posedge clk); #2 stop = 1'b0; cmd.cmd_valid = 1'b0;
    repeat (150) @(negedge clk);
    chk("stopcmd_dc", int'(dc), 3);
    chk("stopcmd_busy", int'(busy), 0);

    send(1, 80, 1);
    wait_dc("ramp57", 57, 8000);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_dc", int'(dc), 0);
    chk("async_rst_busy", int'(busy), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_fstart", int'(frame_start), 1);
    chk("rel_busy", int'(busy), 0);

    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #2;
      cmd.cmd_valid  = ($urandom_range(0, 39) == 0);
      cmd.cmd_mode   = 2'($urandom_range(0, 3));
      cmd.cmd_target = 7'($urandom_range(0, 127));
      cmd.cmd_rate   = 8'($urandom_range(0, 2));
      stop           = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #2 cmd.cmd_valid = 1'b0; stop = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
